arbitro_jogadores: RTL and testbench

ARBITRO_JOGADORES -- requirements
Module: arbitro_jogadores

---
 rtl/arbitro_jogadores.sv | 194 +++++++++++++++++++
 tb/tb_arbitro_jogadores.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/arbitro_jogadores.sv
// Two-player turn arbiter in front of a shared track checker.
// Optional turn timeout is compiled in when ARBITRO_TIMEOUT_EN is defined.
module arbitro_jogadores #(
  parameter int MAX_FALHAS = 3,
  parameter int TEMPO_MAX  = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_j0,
  input  logic       req_j1,
  input  logic [3:0] numero_j0,
  input  logic [3:0] numero_j1,
  input  logic       insere_j0,
  input  logic       insere_j1,
  input  logic       chk_erro,
  input  logic       chk_sucesso,
  output logic       chk_reset,
  output logic [3:0] chk_numero,
  output logic       chk_insere,
  output logic [1:0] vez,
  output logic [1:0] falhas_j0,
  output logic [1:0] falhas_j1,
  output logic [1:0] bloqueado,
  output logic [1:0] vencedor,
  output logic       fim_jogo
);

  typedef enum logic [1:0] {OCIOSO, LIMPA, TURNO, FIM_JOGO} t_estado;

  localparam logic [1:0] L_MAX = 2'(MAX_FALHAS);

  t_estado    r_estado, w_estado_next;
  logic [1:0] r_vez, w_vez_next;
  logic       r_ultimo, w_ultimo_next;
  logic [1:0] r_falhas [2];
  logic [1:0] w_falhas_next [2];
  logic [1:0] r_bloq, w_bloq_next;
  logic [1:0] r_venc, w_venc_next;
  logic       r_fim, w_fim_next;
  logic       r_chk_reset, w_chk_reset_next;
  logic       r_chk_insere, w_chk_insere_next;
  logic [3:0] r_chk_numero, w_chk_numero_next;

  logic [1:0] w_req;
  logic [1:0] w_eleg;
  logic [1:0] w_grant;
  logic [1:0] w_falha_inc [2];
  logic [1:0] w_bloq_falha;
  logic       w_g;
  logic       w_ins_g;
  logic [3:0] w_num_g;
  logic       w_timeout;

  assign w_req   = {req_j1, req_j0};
  assign w_g     = r_vez[1];
  assign w_ins_g = r_vez[1] ? insere_j1 : insere_j0;
  assign w_num_g = r_vez[1] ? numero_j1 : numero_j0;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_jogador
      assign w_eleg[gi]      = w_req[gi] & ~r_bloq[gi];
      assign w_falha_inc[gi] = (r_falhas[gi] == L_MAX) ? r_falhas[gi] : r_falhas[gi] + 2'd1;
      assign w_bloq_falha[gi] = r_bloq[gi] |
                                ((w_g == 1'(gi)) && (w_falha_inc[gi] == L_MAX));
    end
  endgenerate

  // On a tie the player who did not hold the previous turn goes first.
  assign w_grant = (&w_eleg) ? (r_ultimo ? 2'b01 : 2'b10) : w_eleg;

`ifdef ARBITRO_TIMEOUT_EN
  localparam int TW = (TEMPO_MAX > 2) ? $clog2(TEMPO_MAX) : 1;

  logic [TW-1:0] r_timer, w_timer_next;

  always_comb begin
    w_timer_next = '0;
    if (r_estado == TURNO) begin
      w_timer_next = w_ins_g ? '0 : r_timer + 1'b1;
    end
  end

  assign w_timeout = (r_estado == TURNO) && !w_ins_g && (r_timer == TW'(TEMPO_MAX - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_timer <= '0;
    end else begin
      r_timer <= w_timer_next;
    end
  end
`else
  // Constant false: turns end only on the checker flags.
  assign w_timeout = (TEMPO_MAX < 0);
`endif

  always_comb begin
    w_estado_next     = r_estado;
    w_vez_next        = r_vez;
    w_ultimo_next     = r_ultimo;
    w_falhas_next[0]  = r_falhas[0];
    w_falhas_next[1]  = r_falhas[1];
    w_bloq_next       = r_bloq;
    w_venc_next       = r_venc;
    w_fim_next        = r_fim;
    w_chk_reset_next  = 1'b0;
    w_chk_insere_next = 1'b0;
    w_chk_numero_next = r_chk_numero;
    case (r_estado)
      OCIOSO: begin
        if (&r_bloq) begin
          w_estado_next = FIM_JOGO;
          w_fim_next    = 1'b1;
        end else if (|w_eleg) begin
          w_vez_next       = w_grant;
          w_ultimo_next    = w_grant[1];
          w_chk_reset_next = 1'b1;
          w_estado_next    = LIMPA;
        end
      end
      LIMPA: begin
        w_estado_next = TURNO;
      end
      TURNO: begin
        // Error beats success, and a strobe in an ending cycle is dropped.
        if (chk_erro || w_timeout) begin
          w_falhas_next[w_g] = w_falha_inc[w_g];
          w_bloq_next        = w_bloq_falha;
          w_vez_next         = 2'b00;
          if (&w_bloq_falha) begin
            w_estado_next = FIM_JOGO;
            w_fim_next    = 1'b1;
          end else begin
            w_estado_next = OCIOSO;
          end
        end else if (chk_sucesso) begin
          w_venc_next   = r_vez;
          w_fim_next    = 1'b1;
          w_vez_next    = 2'b00;
          w_estado_next = FIM_JOGO;
        end else if (w_ins_g) begin
          w_chk_insere_next = 1'b1;
          w_chk_numero_next = w_num_g;
        end
      end
      FIM_JOGO: begin
        w_estado_next = FIM_JOGO;
      end
      default: begin
        w_estado_next = OCIOSO;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_estado     <= OCIOSO;
      r_vez        <= 2'b00;
      r_ultimo     <= 1'b1;
      r_falhas[0]  <= 2'd0;
      r_falhas[1]  <= 2'd0;
      r_bloq       <= 2'b00;
      r_venc       <= 2'b00;
      r_fim        <= 1'b0;
      r_chk_reset  <= 1'b0;
      r_chk_insere <= 1'b0;
      r_chk_numero <= 4'd0;
    end else begin
      r_estado     <= w_estado_next;
      r_vez        <= w_vez_next;
      r_ultimo     <= w_ultimo_next;
      r_falhas[0]  <= w_falhas_next[0];
      r_falhas[1]  <= w_falhas_next[1];
      r_bloq       <= w_bloq_next;
      r_venc       <= w_venc_next;
      r_fim        <= w_fim_next;
      r_chk_reset  <= w_chk_reset_next;
      r_chk_insere <= w_chk_insere_next;
      r_chk_numero <= w_chk_numero_next;
    end
  end

  assign chk_reset  = r_chk_reset;
  assign chk_insere = r_chk_insere;
  assign chk_numero = r_chk_numero;
  assign vez        = r_vez;
  assign falhas_j0  = r_falhas[0];
  assign falhas_j1  = r_falhas[1];
  assign bloqueado  = r_bloq;
  assign vencedor   = r_venc;
  assign fim_jogo   = r_fim;

endmodule

// File: tb/tb_arbitro_jogadores.sv
// Scoreboard bench for arbitro_jogadores: random turns driven against a
// game-level reference model; a negedge monitor pops expectations on DUT events.
module tb_arbitro_jogadores;

  localparam int MAXF = 3;
  localparam int TMAX = 1000;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req_j0 = 1'b0, req_j1 = 1'b0;
  logic [3:0] numero_j0 = '0, numero_j1 = '0;
  logic       insere_j0 = 1'b0, insere_j1 = 1'b0;
  logic       chk_erro = 1'b0, chk_sucesso = 1'b0;
  logic       chk_reset, chk_insere, fim_jogo;
  logic [3:0] chk_numero;
  logic [1:0] vez, falhas_j0, falhas_j1, bloqueado, vencedor;

  always #5 clk = ~clk;

  arbitro_jogadores #(.MAX_FALHAS(MAXF), .TEMPO_MAX(TMAX)) dut (
    .clk(clk), .reset(reset),
    .req_j0(req_j0), .req_j1(req_j1),
    .numero_j0(numero_j0), .numero_j1(numero_j1),
    .insere_j0(insere_j0), .insere_j1(insere_j1),
    .chk_erro(chk_erro), .chk_sucesso(chk_sucesso),
    .chk_reset(chk_reset), .chk_numero(chk_numero), .chk_insere(chk_insere),
    .vez(vez), .falhas_j0(falhas_j0), .falhas_j1(falhas_j1),
    .bloqueado(bloqueado), .vencedor(vencedor), .fim_jogo(fim_jogo)
  );

  typedef struct {int f0; int f1; int blk; int venc;} t_res;

  int   n_chk = 0;
  int   n_fail = 0;
  int   q_grant[$];
  int   q_dig[$];
  t_res q_res[$];

  // Reference model: game-level bookkeeping only.
  int m_f[2];
  int m_blk[2];
  int m_last;
  int m_over;
  int m_venc;

  task automatic check(input string nome, input int atual, input int esperado);
    n_chk++;
    if (atual != esperado) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nome, atual, esperado, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_f[0] = 0; m_f[1] = 0; m_blk[0] = 0; m_blk[1] = 0;
    m_last = 1; m_over = 0; m_venc = 0;
  endtask

  // Monitor: every chk_reset, chk_insere and end of turn consumes one expectation.
  logic [1:0] vez_ant = 2'b00;
  t_res       res_mon;
  int         e_mon;
  always @(negedge clk) begin
    if (!reset) begin
      vez_ant = 2'b00;
    end else begin
      if (chk_reset) begin
        if (q_grant.size() == 0) check("grant_inesperado", chk_reset, 0);
        else begin
          e_mon = q_grant.pop_front();
          check("vez_grant", vez, e_mon);
          $display("grant vez=%b expected=%0d", vez, e_mon);
        end
      end
      if (chk_insere) begin
        if (q_dig.size() == 0) check("insere_inesperado", chk_insere, 0);
        else begin
          e_mon = q_dig.pop_front();
          check("chk_numero", chk_numero, e_mon);
          $display("digit chk_numero=%0d expected=%0d", chk_numero, e_mon);
        end
      end
      if (vez_ant != 2'b00 && vez == 2'b00) begin
        if (q_res.size() == 0) check("fim_turno_inesperado", vez_ant, 0);
        else begin
          res_mon = q_res.pop_front();
          check("falhas_j0", falhas_j0, res_mon.f0);
          check("falhas_j1", falhas_j1, res_mon.f1);
          check("bloqueado", bloqueado, res_mon.blk);
          check("vencedor", vencedor, res_mon.venc);
          $display("turn end falhas=%0d/%0d bloq=%b venc=%b", falhas_j0, falhas_j1, bloqueado, vencedor);
        end
      end
      vez_ant = vez;
    end
  end

  task automatic push_res();
    t_res r;
    r.f0 = m_f[0]; r.f1 = m_f[1];
    r.blk = m_blk[0] + 2 * m_blk[1];
    r.venc = m_venc;
    q_res.push_back(r);
  endtask

  task automatic drive_idle();
    req_j0 = 0; req_j1 = 0; insere_j0 = 0; insere_j1 = 0;
    chk_erro = 0; chk_sucesso = 0;
  endtask

  task automatic do_reset(input string tag);
    #3 reset = 1'b0;
    #1;
    check({tag, "_vez"}, vez, 0);
    check({tag, "_falhas"}, {falhas_j1, falhas_j0}, 0);
    check({tag, "_bloq_venc"}, {bloqueado, vencedor}, 0);
    check({tag, "_fim_chk"}, {fim_jogo, chk_reset, chk_insere}, 0);
    check({tag, "_chk_numero"}, chk_numero, 0);
    drive_idle();
    q_grant.delete(); q_dig.delete(); q_res.delete();
    model_reset();
    tick(); tick();
    reset = 1'b1;
  endtask

  // Returns 1 if a turn was granted and entered TURNO.
  task automatic grant(input bit r0, input bit r1, output bit ok, output int g);
    bit e0, e1;
    int k;
    ok = 0;
    e0 = r0 && !m_blk[0];
    e1 = r1 && !m_blk[1];
    g = 0;
    req_j0 = r0; req_j1 = r1;
    if (!e0 && !e1) begin
      repeat (3) begin
        tick();
        check("sem_grant_vez", vez, 0);
      end
      req_j0 = 0; req_j1 = 0;
      return;
    end
    g = (e0 && e1) ? ((m_last == 1) ? 0 : 1) : (e0 ? 0 : 1);
    m_last = g;
    q_grant.push_back(1 << g);
    k = 0;
    do begin
      tick();
      k++;
    end while (vez == 0 && k < 5);
    if (vez == 0) begin
      check("grant_demorou", vez, 1 << g);
      req_j0 = 0; req_j1 = 0;
      return;
    end
    req_j0 = 0; req_j1 = 0;
    tick();
    ok = 1;
  endtask

  task automatic play_turn(input bit r0, input bit r1);
    bit ok;
    int g, n, kind;
    grant(r0, r1, ok, g);
    if (!ok) return;
    n = $urandom_range(0, 8);
    for (int i = 0; i < n; i++) begin
      insere_j0 = 1'($urandom); insere_j1 = 1'($urandom);
      numero_j0 = 4'($urandom); numero_j1 = 4'($urandom);
      req_j0 = 1'($urandom); req_j1 = 1'($urandom);
      if (g == 0 && insere_j0) q_dig.push_back(int'(numero_j0));
      if (g == 1 && insere_j1) q_dig.push_back(int'(numero_j1));
      tick();
    end
    kind = $urandom_range(0, 9);
    chk_sucesso = (kind <= 2);
    chk_erro = (kind >= 2);
    insere_j0 = 1'($urandom); insere_j1 = 1'($urandom);
    numero_j0 = 4'($urandom); numero_j1 = 4'($urandom);
    req_j0 = 0; req_j1 = 0;
    if (!chk_erro) begin
      m_over = 1; m_venc = 1 << g;
    end else begin
      if (m_f[g] < MAXF) m_f[g]++;
      if (m_f[g] == MAXF) m_blk[g] = 1;
      if (m_blk[0] && m_blk[1]) m_over = 1;
    end
    push_res();
    tick();
    drive_idle();
    check("vez_apos_fim", vez, 0);
    tick();
    check("fim_jogo", fim_jogo, m_over);
  endtask

  initial begin
    int turns;
    bit ok;
    int g, c;
    model_reset();
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    check("reset_vez", vez, 0);
    check("reset_fim", fim_jogo, 0);
    check("reset_falhas", {falhas_j1, falhas_j0}, 0);
    reset = 1'b1;
    tick();

    for (int game = 0; game < 6; game++) begin
      play_turn(1, 1);
      turns = 0;
      while (!m_over && turns < 30) begin
        play_turn($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
        turns++;
      end
      for (int i = 0; i < 8; i++) begin
        req_j0 = 1'($urandom); req_j1 = 1'($urandom);
        insere_j0 = 1'($urandom); insere_j1 = 1'($urandom);
        tick();
        check("fim_absorvente_vez", vez, 0);
        check("fim_absorvente_fim", fim_jogo, m_over);
      end
      drive_idle();
      do_reset("reset_jogo");
      tick();
    end

    // Reset in the middle of a turn: nothing is counted.
    grant(1, 1, ok, g);
    check("mid_grant_ok", int'(ok), 1);
    tick(); tick();
    do_reset("reset_turno");
    tick();
    check("mid_falhas_j0", falhas_j0, 0);

    // Idle turn for j0.
    grant(1, 0, ok, g);
`ifdef ARBITRO_TIMEOUT_EN
    m_f[0] = 1;
    push_res();
    c = 0;
    while (vez != 0 && c < TMAX + 100) begin
      tick();
      c++;
    end
    check("ciclos_timeout", c, TMAX);
`else
    c = 0;
    repeat (2 * TMAX) tick();
    check("vez_sem_timeout", vez, 1);
    check("falhas_sem_timeout", falhas_j0, 0);
`endif
    do_reset("reset_final");
    tick();

    check("fila_grant_vazia", q_grant.size(), 0);
    check("fila_digito_vazia", q_dig.size(), 0);
    check("fila_resultado_vazia", q_res.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
